frame_reader: RTL and testbench
===============================

# frame_reader

Consumer on the window buffer's read side. Each frame it pulls FRAME_LEN samples in order through the window buffer's read handshake, multiplies each by a window coefficient from an external synchronous ROM (Q1.15), rounds and saturates, and streams the result to the FFT stage over valid/ready. After the last windowed sample is accepted downstream, it pulses the window buffer's move request to slide the window by one hop.

## Interface

- WIDTH, 16: sample and output width, signed two's complement.
- FRAME_LEN, 306: samples per frame; must match the window buffer size.
- AW, 9: coefficient address width; requires 2^AW ≥ FRAME_LEN.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable_i  in  1  level; run frames continuously while high.
- wb_data_i  in  WIDTH  window buffer read data, combinational from the buffer.
- wb_valid_i  in  1  window buffer has a readable sample.
- wb_rd_en_o  out  1  advance the window buffer read pointer; zero-extended onto the buffer's 10-bit read-enable.
- wb_move_o  out  1  one-cycle pulse: slide window by one hop (buffer start_move).
- coef_addr_o  out  AW  coefficient ROM address = sample index in frame.
- coef_en_o  out  1  ROM read enable; ROM output holds while low.
- coef_i  in  WIDTH  ROM data, valid the cycle after the address is registered.
- out_data_o  out  WIDTH  windowed sample.
- out_valid_o  out  1  output valid.
- out_last_o  out  1  marks sample FRAME_LEN-1.
- out_ready_i  in  1  downstream accept.
- busy_o  out  1  FSM not in IDLE.
- frame_cnt_o  out  16  completed frames, wraps at 2^16.

## Operation

- FSM states: IDLE, READ, DRAIN, MOVE, HOLD.
- IDLE → READ when enable_i = 1. idx = 0.
- Pipeline advance: adv = !out_valid_o || out_ready_i. coef_en_o = adv.
- READ issue condition: adv && wb_valid_i && idx < FRAME_LEN.
  - wb_rd_en_o = issue.
  - coef_addr_o = idx.
  - At the issue edge: s1_sample ← wb_data_i, s1_valid ← 1, s1_last ← (idx == FRAME_LEN-1), idx++.
- Stage 2 (on adv): prod ← s1_sample × coef_i, 2·WIDTH-bit signed.
- Output register (on adv): out_data_o ← sat((prod + 2^(WIDTH-2)) >>> (WIDTH-1)), arithmetic shift, round half up.
  - sat clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - The only overflow case is (-32768)·(-32768), which yields 0x7FFF.
- Valid and last bits travel with the data. When adv = 0, every stage and the ROM output hold. No sample is dropped or duplicated.
- READ → DRAIN after the issue with idx = FRAME_LEN-1.
- DRAIN → MOVE on the handshake out_valid_o && out_ready_i && out_last_o.
- MOVE: wb_move_o = 1 for exactly one cycle; idx ← 0; frame_cnt_o++. Then → HOLD.
- HOLD: 2 cycles with no issue, masking the window buffer's refill transition. Then → READ if enable_i, else → IDLE.
- enable_i falling mid-frame: the current frame completes, including MOVE, then the FSM goes to IDLE.
- wb_valid_i low in READ: issue stalls and idx holds. Gaps are arbitrary.
- Reset, asynchronous, any state:
  - FSM = IDLE; idx, all pipeline valids, wb_rd_en_o, wb_move_o, out_valid_o, out_last_o, out_data_o, frame_cnt_o, busy_o = 0; coef_addr_o = 0.
  - coef_en_o = 1, because adv = 1 with out_valid_o = 0.

## Timing

- wb_rd_en_o, coef_addr_o and coef_en_o are combinational from state and inputs. All other outputs are registered.
- Latency: a sample issued in cycle N appears on out_valid_o in cycle N+3 when out_ready_i stays high.
- Throughput: 1 sample/cycle with wb_valid_i and out_ready_i continuously high.
- Minimum frame period: FRAME_LEN issue cycles + 3 drain + 1 MOVE + 2 HOLD = FRAME_LEN+6 cycles.
- wb_move_o rises the cycle after the last-sample handshake. The first issue of the next frame is no earlier than 3 cycles after wb_move_o.
- out_valid_o never drops without a handshake. out_data_o and out_last_o are stable while out_valid_o && !out_ready_i.

## Test plan

- Unity window: coef = 0x7FFF, samples 0..305 ramp, ready always high → outputs 0..305, since e.g. 100·32767 → 100. out_last_o only on the 306th output. First output 3 cycles after first wb_rd_en_o. Exactly 306 wb_rd_en_o pulses.
- Rounding and saturation:
  - sample 3, coef 0x4000 → 2.
  - sample -3, coef 0x4000 → -1.
  - sample -32768, coef -32768 → 0x7FFF.
  - sample 32767, coef -32768 → -32767.
- Backpressure: out_ready_i low for 10 cycles at output 50, plus random 30% ready → no wb_rd_en_o while adv = 0, and all 306 outputs arrive in order with correct values.
- Source gaps: wb_valid_i random 50% → wb_rd_en_o only when wb_valid_i = 1, and the output sequence is unchanged.
- Multi-frame: enable_i high for 3 frames → wb_move_o exactly once per frame, one cycle after each last handshake. No wb_rd_en_o for 2 cycles after each move. frame_cnt_o = 3. Deassert enable_i at sample 100 of frame 4 → frame 4 completes, then IDLE and busy_o = 0.
- Reset mid-frame at sample 150 → all outputs return to their reset values the same cycle. After release with enable_i high, a fresh frame starts at coef_addr_o = 0.

Source files
------------

// File: rtl/frame_reader_if.sv
// Bundle of the window-buffer read port, coefficient ROM port and FFT-side stream.
// The master modport is the frame_reader view; slave is the surrounding environment.
interface frame_reader_if #(
   parameter int WIDTH = 16,
   parameter int AW    = 9
);
   logic [WIDTH-1:0] wb_data_i;
   logic             wb_valid_i;
   logic             wb_rd_en_o;
   logic             wb_move_o;
   logic [AW-1:0]    coef_addr_o;
   logic             coef_en_o;
   logic [WIDTH-1:0] coef_i;
   logic [WIDTH-1:0] out_data_o;
   logic             out_valid_o;
   logic             out_last_o;
   logic             out_ready_i;

   modport master (
      input  wb_data_i, wb_valid_i, coef_i, out_ready_i,
      output wb_rd_en_o, wb_move_o, coef_addr_o, coef_en_o,
      output out_data_o, out_valid_o, out_last_o
   );

   modport slave (
      output wb_data_i, wb_valid_i, coef_i, out_ready_i,
      input  wb_rd_en_o, wb_move_o, coef_addr_o, coef_en_o,
      input  out_data_o, out_valid_o, out_last_o
   );
endinterface

// File: rtl/frame_reader.sv
// Pulls one frame of samples from the window buffer, applies a Q1.15 window from an
// external synchronous ROM with round-half-up and saturation, and streams to the FFT.
module frame_reader #(
   parameter int WIDTH     = 16,
   parameter int FRAME_LEN = 306,
   parameter int AW        = 9
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable_i,
   frame_reader_if.master      bus,
   output logic                busy_o,
   output logic [15:0]         frame_cnt_o
);

   localparam int PW = 2 * WIDTH;
   localparam logic [AW-1:0]        LAST_IDX = AW'(FRAME_LEN - 1);
   localparam logic signed [PW-1:0] ROUND_K  = PW'(2 ** (WIDTH - 2));
   localparam logic signed [PW-1:0] SAT_MAX  = PW'(2 ** (WIDTH - 1) - 1);
   localparam logic signed [PW-1:0] SAT_MIN  = PW'(-(2 ** (WIDTH - 1)));

   typedef enum logic [2:0] {IDLE, READ, DRAIN, MOVE, HOLD} state_t;

   state_t                   state_q, state_d;
   logic [AW-1:0]            idx_q, idx_d;
   logic                     holdCnt_q, holdCnt_d;
   logic                     wbMove_q;
   logic                     busy_q;
   logic [15:0]              frameCnt_q;

   logic                     s1Valid_q, s1Last_q;
   logic signed [WIDTH-1:0]  s1Sample_q;
   logic                     p2Valid_q, p2Last_q;
   logic signed [PW-1:0]     prod_q;
   logic                     outValid_q, outLast_q;
   logic [WIDTH-1:0]         outData_q;

   logic                     adv;
   logic                     issue;
   logic signed [PW-1:0]     rounded;
   logic signed [PW-1:0]     shifted;
   logic [WIDTH-1:0]         satData;

   // The whole pipeline and the ROM output register move together on adv.
   assign adv   = !outValid_q || bus.out_ready_i;
   assign issue = (state_q == READ) && adv && bus.wb_valid_i && (idx_q <= LAST_IDX);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      holdCnt_d = holdCnt_q;
      case (state_q)
         IDLE: begin
            idx_d = '0;
            if (enable_i) state_d = READ;
         end
         READ: begin
            if (issue) begin
               idx_d = idx_q + 1'b1;
               if (idx_q == LAST_IDX) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (outValid_q && bus.out_ready_i && outLast_q) state_d = MOVE;
         end
         MOVE: begin
            idx_d     = '0;
            holdCnt_d = 1'b0;
            state_d   = HOLD;
         end
         HOLD: begin
            holdCnt_d = 1'b1;
            if (holdCnt_q) state_d = enable_i ? READ : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         holdCnt_q  <= 1'b0;
         wbMove_q   <= 1'b0;
         busy_q     <= 1'b0;
         frameCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         holdCnt_q <= holdCnt_d;
         wbMove_q  <= (state_d == MOVE);
         busy_q    <= (state_d != IDLE);
         if (state_d == MOVE) frameCnt_q <= frameCnt_q + 16'd1;
      end
   end

   // Rounded result spans [-2^(W-1)+1, 2^(W-1)]; both clamps kept for clarity.
   always_comb begin
      rounded = prod_q + ROUND_K;
      shifted = rounded >>> (WIDTH - 1);
      if (shifted > SAT_MAX)      satData = SAT_MAX[WIDTH-1:0];
      else if (shifted < SAT_MIN) satData = SAT_MIN[WIDTH-1:0];
      else                        satData = shifted[WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1Valid_q  <= 1'b0;
         s1Last_q   <= 1'b0;
         s1Sample_q <= '0;
         p2Valid_q  <= 1'b0;
         p2Last_q   <= 1'b0;
         prod_q     <= '0;
         outValid_q <= 1'b0;
         outLast_q  <= 1'b0;
         outData_q  <= '0;
      end else if (adv) begin
         s1Valid_q  <= issue;
         s1Last_q   <= issue && (idx_q == LAST_IDX);
         if (issue) s1Sample_q <= bus.wb_data_i;
         p2Valid_q  <= s1Valid_q;
         p2Last_q   <= s1Last_q;
         prod_q     <= PW'(s1Sample_q) * PW'($signed(bus.coef_i));
         outValid_q <= p2Valid_q;
         outLast_q  <= p2Last_q;
         outData_q  <= satData;
      end
   end

   assign bus.wb_rd_en_o  = issue;
   assign bus.wb_move_o   = wbMove_q;
   assign bus.coef_addr_o = idx_q;
   assign bus.coef_en_o   = adv;
   assign bus.out_data_o  = outData_q;
   assign bus.out_valid_o = outValid_q;
   assign bus.out_last_o  = outLast_q;
   assign busy_o          = busy_q;
   assign frame_cnt_o     = frameCnt_q;

endmodule

// File: tb/tb_frame_reader.sv
// Scoreboard bench for frame_reader: window buffer and coefficient ROM models drive the
// DUT, expected outputs are queued per frame and popped by a negedge monitor.
module tb_frame_reader;
   localparam int WIDTH     = 16;
   localparam int FRAME_LEN = 306;
   localparam int AW        = 9;

   typedef struct { int data; bit last; } expT;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        busy;
   logic [15:0] frameCnt;

   frame_reader_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

   frame_reader #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .enable_i(enable), .bus(bus),
      .busy_o(busy), .frame_cnt_o(frameCnt)
   );

   always #5 clk = ~clk;

   logic [15:0] srcMem  [0:FRAME_LEN-1];
   logic [15:0] coefRom [0:(1<<AW)-1];
   logic [15:0] coefQ;
   int          rdPtr = 0;
   expT         expQ[$];

   int checks = 0, failures = 0, cyc = 0;
   int validPct = 100, readyPct = 100;
   int stallLeft = 0, stallArmed = 0;
   bit rdFire = 0, moveSeen = 0;
   int rdCount, outCount, moveCount;
   int firstRdCycle, firstOutCycle, firstRdAddr;
   int moveCycle = -100, lastHsCycle = -100;
   int addrErr = 0, gapErr = 0, stallRdErr = 0, rdAfterMoveErr = 0, moveTimingErr = 0;

   assign bus.wb_data_i = (rdPtr < FRAME_LEN) ? srcMem[rdPtr] : 16'h0000;
   assign bus.coef_i    = coefQ;

   // Synchronous coefficient ROM that holds its output while not enabled.
   always @(posedge clk) if (bus.coef_en_o) coefQ <= coefRom[bus.coef_addr_o];

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Window buffer model and handshake driver, updated just after each rising edge.
   initial begin
      bus.wb_valid_i  = 1'b0;
      bus.out_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rdFire) rdPtr++;
         if (moveSeen) rdPtr = 0;
         rdFire   = 0;
         moveSeen = 0;
         bus.wb_valid_i = ($urandom_range(99) < validPct);
         if (stallLeft > 0) begin
            bus.out_ready_i = 1'b0;
            stallLeft--;
         end else if (stallArmed != 0 && outCount >= 50) begin
            stallArmed      = 0;
            stallLeft       = 9;
            bus.out_ready_i = 1'b0;
         end else begin
            bus.out_ready_i = ($urandom_range(99) < readyPct);
         end
      end
   end

   // Monitor: protocol bookkeeping and scoreboard pops on every output handshake.
   initial forever begin
      expT e;
      @(negedge clk);
      rdFire   = bus.wb_rd_en_o;
      moveSeen = bus.wb_move_o;
      if (rst_n) begin
         if (bus.wb_rd_en_o) begin
            rdCount++;
            if (firstRdCycle < 0) begin
               firstRdCycle = cyc;
               firstRdAddr  = int'(bus.coef_addr_o);
            end
            if (int'(bus.coef_addr_o) != rdPtr) addrErr++;
            if (!bus.wb_valid_i) gapErr++;
            if (bus.out_valid_o && !bus.out_ready_i) stallRdErr++;
            if (cyc <= moveCycle + 2) rdAfterMoveErr++;
         end
         if (bus.out_valid_o && firstOutCycle < 0) firstOutCycle = cyc;
         if (bus.wb_move_o) begin
            moveCount++;
            if (cyc != lastHsCycle + 1) moveTimingErr++;
            moveCycle = cyc;
         end
         if (bus.out_valid_o && bus.out_ready_i) begin
            outCount++;
            if (bus.out_last_o) lastHsCycle = cyc;
            if (expQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_output: got data %0d, expected no output", $signed(bus.out_data_o));
            end else begin
               e = expQ.pop_front();
               checkOutput("out_data", int'($signed(bus.out_data_o)), e.data);
               checkOutput("out_last", int'(bus.out_last_o), int'(e.last));
            end
         end
      end
   end

   // Loads buffer/ROM contents and queues hand-computed expectations for nFrames frames.
   task automatic applyStimulus(input int mode, input int nFrames);
      int rSample[8] = '{3, -3, -32768, 32767, 1, -1, 32767, 1000};
      int rCoef[8]   = '{16384, 16384, -32768, -32768, 16384, 16384, 32767, 16384};
      int rExp[8]    = '{2, -1, 32767, -32767, 1, 0, 32766, 500};
      int expVal[FRAME_LEN];
      for (int i = 0; i < FRAME_LEN; i++) begin
         if (mode == 0) begin
            srcMem[i]  = 16'(i);
            coefRom[i] = 16'h7FFF;
            expVal[i]  = i;
         end else if (i < 8) begin
            srcMem[i]  = 16'(rSample[i]);
            coefRom[i] = 16'(rCoef[i]);
            expVal[i]  = rExp[i];
         end else begin
            srcMem[i]  = 16'(i);
            coefRom[i] = 16'h4000;
            expVal[i]  = (i + 1) / 2;
         end
      end
      for (int f = 0; f < nFrames; f++)
         for (int i = 0; i < FRAME_LEN; i++)
            expQ.push_back('{data: expVal[i], last: (i == FRAME_LEN - 1)});
   endtask

   task automatic resetCounters();
      rdCount = 0; outCount = 0; moveCount = 0;
      firstRdCycle = -1; firstOutCycle = -1; firstRdAddr = -1;
   endtask

   task automatic waitRdCount(input int target);
      int n = 0;
      while (rdCount < target && n < 5000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("rd_count_reached", (rdCount >= target) ? 1 : 0, 1);
   endtask

   task automatic waitMoves(input int target);
      int n = 0;
      while (moveCount < target && n < 5000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("moves_reached", (moveCount >= target) ? 1 : 0, 1);
   endtask

   task automatic waitIdle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 5000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("busy_idle", int'(busy), 0);
   endtask

   task automatic runOneFrame();
      resetCounters();
      enable = 1'b1;
      waitRdCount(1);
      enable = 1'b0;
      waitIdle();
      repeat (2) @(negedge clk);
   endtask

   task automatic checkResetState();
      checkOutput("rst_wb_rd_en", int'(bus.wb_rd_en_o), 0);
      checkOutput("rst_wb_move", int'(bus.wb_move_o), 0);
      checkOutput("rst_coef_addr", int'(bus.coef_addr_o), 0);
      checkOutput("rst_coef_en", int'(bus.coef_en_o), 1);
      checkOutput("rst_out_valid", int'(bus.out_valid_o), 0);
      checkOutput("rst_out_last", int'(bus.out_last_o), 0);
      checkOutput("rst_out_data", int'(bus.out_data_o), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_frame_cnt", int'(frameCnt), 0);
   endtask

   task automatic endTest();
      checkOutput("queue_drained", expQ.size(), 0);
      checkOutput("addr_tracks_index", addrErr, 0);
      checkOutput("rd_without_valid", gapErr, 0);
      checkOutput("rd_while_stalled", stallRdErr, 0);
      checkOutput("rd_soon_after_move", rdAfterMoveErr, 0);
      checkOutput("move_timing", moveTimingErr, 0);
      addrErr = 0; gapErr = 0; stallRdErr = 0; rdAfterMoveErr = 0; moveTimingErr = 0;
      expQ.delete();
   endtask

   initial begin
      enable = 1'b0;
      rst_n  = 1'b1;
      resetCounters();
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1 checkResetState();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] unity window ramp");
      applyStimulus(0, 1);
      runOneFrame();
      checkOutput("unity_rd_pulses", rdCount, FRAME_LEN);
      checkOutput("unity_latency", firstOutCycle - firstRdCycle, 3);
      checkOutput("unity_moves", moveCount, 1);
      checkOutput("unity_frame_cnt", int'(frameCnt), 1);
      endTest();

      $display("[TB] rounding and saturation");
      applyStimulus(1, 1);
      runOneFrame();
      checkOutput("round_rd_pulses", rdCount, FRAME_LEN);
      checkOutput("round_frame_cnt", int'(frameCnt), 2);
      endTest();

      $display("[TB] backpressure");
      readyPct = 70;
      stallArmed = 1;
      applyStimulus(0, 1);
      runOneFrame();
      checkOutput("bp_rd_pulses", rdCount, FRAME_LEN);
      checkOutput("bp_outputs", outCount, FRAME_LEN);
      endTest();
      readyPct = 100;

      $display("[TB] source gaps");
      validPct = 50;
      applyStimulus(0, 1);
      runOneFrame();
      checkOutput("gap_rd_pulses", rdCount, FRAME_LEN);
      endTest();
      validPct = 100;

      $display("[TB] multi-frame");
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(0, 4);
      resetCounters();
      enable = 1'b1;
      waitMoves(3);
      @(negedge clk);
      checkOutput("multi_frame_cnt3", int'(frameCnt), 3);
      checkOutput("multi_moves3", moveCount, 3);
      waitRdCount(3 * FRAME_LEN + 100);
      enable = 1'b0;
      waitIdle();
      checkOutput("multi_frame_cnt4", int'(frameCnt), 4);
      checkOutput("multi_moves4", moveCount, 4);
      checkOutput("multi_rd_pulses", rdCount, 4 * FRAME_LEN);
      endTest();

      $display("[TB] reset mid-frame");
      applyStimulus(0, 1);
      resetCounters();
      enable = 1'b1;
      waitRdCount(150);
      #2 rst_n = 1'b0;
      #1 checkResetState();
      expQ.delete();
      @(posedge clk);
      #3 rdPtr = 0;
      rdFire = 0;
      resetCounters();
      applyStimulus(0, 1);
      @(negedge clk);
      rst_n = 1'b1;
      waitRdCount(1);
      enable = 1'b0;
      waitIdle();
      checkOutput("post_rst_first_addr", firstRdAddr, 0);
      checkOutput("post_rst_rd_pulses", rdCount, FRAME_LEN);
      checkOutput("post_rst_frame_cnt", int'(frameCnt), 1);
      endTest();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
